// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the single register-file write port (ALU, MEM, MD round-robin)
// plus a per-register pending-write scoreboard used by issue for RAW hazard checks.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic              md_valid,
  input  logic [ADDR_W-1:0] md_addr,
  input  logic [DATA_W-1:0] md_data,
  output logic              md_ready,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic [15:0]       stall_cnt
);

  localparam int NREG = 1 << ADDR_W;

  typedef enum logic [1:0] {
    RR_ALU = 2'd0,
    RR_MEM = 2'd1,
    RR_MD  = 2'd2
  } rr_e;

  rr_e               r_rr;
  rr_e               w_rr_nxt;
  logic [2:0]        w_valid;
  logic [2:0]        w_grant;
  logic [ADDR_W-1:0] w_gaddr;
  logic [DATA_W-1:0] w_gdata;
  logic              w_stall;
  logic [NREG-1:0]   r_busy;
  logic [NREG-1:0]   w_busy_nxt;
  logic              r_regwrite;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic [15:0]       r_stall;

  // Round-robin grant: search starts at r_rr; grants depend only on valids and r_rr.
  always_comb begin
    w_valid  = {md_valid, mem_valid, alu_valid};
    w_grant  = 3'b000;
    w_rr_nxt = r_rr;
    if (rst) begin
      w_grant = 3'b000;
    end else begin
      case (r_rr)
        RR_MEM: begin
          if (w_valid[1])      w_grant = 3'b010;
          else if (w_valid[2]) w_grant = 3'b100;
          else if (w_valid[0]) w_grant = 3'b001;
          else                 w_grant = 3'b000;
        end
        RR_MD: begin
          if (w_valid[2])      w_grant = 3'b100;
          else if (w_valid[0]) w_grant = 3'b001;
          else if (w_valid[1]) w_grant = 3'b010;
          else                 w_grant = 3'b000;
        end
        default: begin
          if (w_valid[0])      w_grant = 3'b001;
          else if (w_valid[1]) w_grant = 3'b010;
          else if (w_valid[2]) w_grant = 3'b100;
          else                 w_grant = 3'b000;
        end
      endcase
    end
    case (w_grant)
      3'b001:  w_rr_nxt = RR_MEM;
      3'b010:  w_rr_nxt = RR_MD;
      3'b100:  w_rr_nxt = RR_ALU;
      default: w_rr_nxt = r_rr;
    endcase
  end

  // Granted payload mux and stall detection (two or more valids always leaves one waiting).
  always_comb begin
    w_gaddr = alu_addr;
    w_gdata = alu_data;
    case (w_grant)
      3'b010: begin
        w_gaddr = mem_addr;
        w_gdata = mem_data;
      end
      3'b100: begin
        w_gaddr = md_addr;
        w_gdata = md_data;
      end
      default: begin
        w_gaddr = alu_addr;
        w_gdata = alu_data;
      end
    endcase
    w_stall = (alu_valid & mem_valid) | (alu_valid & md_valid) | (mem_valid & md_valid);
  end

  // Scoreboard next state: clear on the registered write, then set on issue (set wins).
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_regwrite) begin
      w_busy_nxt[r_waddr] = 1'b0;
    end else begin
      w_busy_nxt[r_waddr] = r_busy[r_waddr];
    end
    if (iss_valid && (iss_addr != {ADDR_W{1'b0}})) begin
      w_busy_nxt[iss_addr] = 1'b1;
    end else begin
      w_busy_nxt[iss_addr] = w_busy_nxt[iss_addr];
    end
    w_busy_nxt[0] = 1'b0;
  end

  // State and registered write-port outputs; grants to $zero are consumed silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr       <= RR_ALU;
      r_busy     <= {NREG{1'b0}};
      r_regwrite <= 1'b0;
      r_waddr    <= {ADDR_W{1'b0}};
      r_wdata    <= {DATA_W{1'b0}};
      r_stall    <= 16'd0;
    end else begin
      r_rr   <= w_rr_nxt;
      r_busy <= w_busy_nxt;
      if ((w_grant != 3'b000) && (w_gaddr != {ADDR_W{1'b0}})) begin
        r_regwrite <= 1'b1;
        r_waddr    <= w_gaddr;
        r_wdata    <= w_gdata;
      end else begin
        r_regwrite <= 1'b0;
      end
      if (w_stall && (r_stall != 16'hFFFF)) begin
        r_stall <= r_stall + 16'd1;
      end else begin
        r_stall <= r_stall;
      end
    end
  end

  assign alu_ready     = w_grant[0];
  assign mem_ready     = w_grant[1];
  assign md_ready      = w_grant[2];
  assign RegWrite      = r_regwrite;
  assign WriteRegister = r_waddr;
  assign WriteData     = r_wdata;
  assign rs_busy       = r_busy[rs_addr];
  assign rt_busy       = r_busy[rt_addr];
  assign stall_cnt     = r_stall;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, async reset sequence,
// random traffic against a behavioural model, and stall counter saturation.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  p_v;
  logic [4:0]  p_a [3];
  logic [31:0] p_d [3];
  logic        iss_v;
  logic [4:0]  iss_a, rs_a, rt_a;
  logic        alu_ready, mem_ready, md_ready;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic        rs_busy, rt_busy;
  logic [15:0] stall_cnt;

  int checks;
  int failures;

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(p_v[0]), .alu_addr(p_a[0]), .alu_data(p_d[0]), .alu_ready(alu_ready),
    .mem_valid(p_v[1]), .mem_addr(p_a[1]), .mem_data(p_d[1]), .mem_ready(mem_ready),
    .md_valid(p_v[2]),  .md_addr(p_a[2]),  .md_data(p_d[2]),  .md_ready(md_ready),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .iss_valid(iss_v), .iss_addr(iss_a), .rs_addr(rs_a), .rt_addr(rt_a),
    .rs_busy(rs_busy), .rt_busy(rt_busy), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: round-robin pointer as an integer, busy bits as an array.
  int          m_rr;
  bit          m_busy [32];
  bit          m_rw;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  int          m_stall;
  int          last_g;

  typedef struct {
    logic [2:0]  v;
    logic [4:0]  a0, a1, a2;
    logic [31:0] d0, d1, d2;
    logic        iv;
    logic [4:0]  ia;
    logic [2:0]  e_gnt;
    logic        e_rw;
    logic [4:0]  e_wr;
    logic [15:0] e_stall;
    logic        e_rsb;
  } vec_t;

  vec_t vt [17];

  function automatic vec_t mk(logic [2:0] v, logic [4:0] a0, logic [4:0] a1, logic [4:0] a2,
                              logic [31:0] d0, logic [31:0] d1, logic [31:0] d2,
                              logic iv, logic [4:0] ia, logic [2:0] e_gnt, logic e_rw,
                              logic [4:0] e_wr, logic [15:0] e_stall, logic e_rsb);
    vec_t r;
    r.v = v; r.a0 = a0; r.a1 = a1; r.a2 = a2; r.d0 = d0; r.d1 = d1; r.d2 = d2;
    r.iv = iv; r.ia = ia; r.e_gnt = e_gnt; r.e_rw = e_rw; r.e_wr = e_wr;
    r.e_stall = e_stall; r.e_rsb = e_rsb;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick();
    int idx;
    for (int k = 0; k < 3; k++) begin
      idx = (m_rr + k) % 3;
      if (p_v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_rr = 0; m_rw = 1'b0; m_wa = 5'd0; m_wd = 32'd0; m_stall = 0; last_g = -1;
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
  endtask

  task automatic check_model();
    int g;
    logic [2:0] eg;
    g  = rst ? -1 : pick();
    eg = (g < 0) ? 3'b000 : (3'b001 << g);
    chk("ready", {29'd0, md_ready, mem_ready, alu_ready}, {29'd0, eg});
    chk("RegWrite", {31'd0, RegWrite}, {31'd0, m_rw});
    if (m_rw) begin
      chk("WriteRegister", {27'd0, WriteRegister}, {27'd0, m_wa});
      chk("WriteData", WriteData, m_wd);
    end
    chk("stall_cnt", {16'd0, stall_cnt}, m_stall);
    chk("rs_busy", {31'd0, rs_busy}, {31'd0, m_busy[rs_a]});
    chk("rt_busy", {31'd0, rt_busy}, {31'd0, m_busy[rt_a]});
  endtask

  task automatic advance();
    int g;
    int nv;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      g  = pick();
      nv = int'(p_v[0]) + int'(p_v[1]) + int'(p_v[2]);
      if (m_rw) m_busy[m_wa] = 1'b0;
      if (iss_v && iss_a != 5'd0) m_busy[iss_a] = 1'b1;
      if (g >= 0) begin
        m_rr = (g + 1) % 3;
        if (p_a[g] != 5'd0) begin
          m_rw = 1'b1; m_wa = p_a[g]; m_wd = p_d[g];
        end else begin
          m_rw = 1'b0;
        end
      end else begin
        m_rw = 1'b0;
      end
      if (nv > ((g >= 0) ? 1 : 0) && m_stall < 65535) m_stall++;
      last_g = g;
    end
    #1;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; p_v = 3'b111; iss_v = 1'b0; iss_a = 5'd0; rs_a = 5'd0; rt_a = 5'd0;
    for (int j = 0; j < 3; j++) begin p_a[j] = 5'd1; p_d[j] = 32'd0; end
    model_reset();
    #3;
    chk("rst_ready", {29'd0, md_ready, mem_ready, alu_ready}, 32'd0);
    chk("rst_RegWrite", {31'd0, RegWrite}, 32'd0);
    chk("rst_WriteRegister", {27'd0, WriteRegister}, 32'd0);
    chk("rst_WriteData", WriteData, 32'd0);
    chk("rst_stall", {16'd0, stall_cnt}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    vt[0]  = mk(3'b001, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF, 32'd0, 32'd0, 1'b0, 5'd0, 3'b001, 1'b0, 5'd0, 16'd0, 1'b0);
    vt[1]  = mk(3'b010, 5'd0, 5'd0, 5'd0, 32'd0, 32'h1234, 32'd0, 1'b0, 5'd0, 3'b010, 1'b1, 5'd5, 16'd0, 1'b0);
    vt[2]  = mk(3'b100, 5'd0, 5'd0, 5'd3, 32'd0, 32'd0, 32'h33, 1'b0, 5'd0, 3'b100, 1'b0, 5'd0, 16'd0, 1'b0);
    vt[3]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 1'b0, 5'd0, 3'b001, 1'b1, 5'd3, 16'd0, 1'b0);
    vt[4]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 1'b0, 5'd0, 3'b010, 1'b1, 5'd1, 16'd1, 1'b0);
    vt[5]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 1'b0, 5'd0, 3'b100, 1'b1, 5'd2, 16'd2, 1'b0);
    vt[6]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 1'b0, 5'd0, 3'b001, 1'b1, 5'd3, 16'd3, 1'b0);
    vt[7]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 1'b0, 5'd0, 3'b010, 1'b1, 5'd1, 16'd4, 1'b0);
    vt[8]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 1'b0, 5'd0, 3'b100, 1'b1, 5'd2, 16'd5, 1'b0);
    vt[9]  = mk(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b1, 5'd8, 3'b000, 1'b1, 5'd3, 16'd6, 1'b0);
    vt[10] = mk(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 3'b000, 1'b0, 5'd0, 16'd6, 1'b1);
    vt[11] = mk(3'b001, 5'd8, 5'd0, 5'd0, 32'hAA, 32'd0, 32'd0, 1'b0, 5'd0, 3'b001, 1'b0, 5'd0, 16'd6, 1'b1);
    vt[12] = mk(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b1, 5'd8, 3'b000, 1'b1, 5'd8, 16'd6, 1'b1);
    vt[13] = mk(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 3'b000, 1'b0, 5'd0, 16'd6, 1'b1);
    vt[14] = mk(3'b001, 5'd8, 5'd0, 5'd0, 32'hBB, 32'd0, 32'd0, 1'b0, 5'd0, 3'b001, 1'b0, 5'd0, 16'd6, 1'b1);
    vt[15] = mk(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 3'b000, 1'b1, 5'd8, 16'd6, 1'b1);
    vt[16] = mk(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 3'b000, 1'b0, 5'd0, 16'd6, 1'b0);

    for (int i = 0; i < 17; i++) begin
      p_v = vt[i].v;
      p_a[0] = vt[i].a0; p_a[1] = vt[i].a1; p_a[2] = vt[i].a2;
      p_d[0] = vt[i].d0; p_d[1] = vt[i].d1; p_d[2] = vt[i].d2;
      iss_v = vt[i].iv; iss_a = vt[i].ia; rs_a = 5'd8; rt_a = 5'd0;
      #4;
      check_model();
      chk($sformatf("tbl%0d_ready", i), {29'd0, md_ready, mem_ready, alu_ready}, {29'd0, vt[i].e_gnt});
      chk($sformatf("tbl%0d_rw", i), {31'd0, RegWrite}, {31'd0, vt[i].e_rw});
      if (vt[i].e_rw) chk($sformatf("tbl%0d_wr", i), {27'd0, WriteRegister}, {27'd0, vt[i].e_wr});
      if (i == 1) chk("tbl1_wdata", WriteData, 32'hDEADBEEF);
      chk($sformatf("tbl%0d_stall", i), {16'd0, stall_cnt}, {16'd0, vt[i].e_stall});
      chk($sformatf("tbl%0d_rs_busy", i), {31'd0, rs_busy}, {31'd0, vt[i].e_rsb});
      advance();
    end

    // Asynchronous reset between edges while a write is in flight and r9 is busy.
    p_v = 3'b001; p_a[0] = 5'd10; p_d[0] = 32'h55; iss_v = 1'b1; iss_a = 5'd9; rs_a = 5'd9; rt_a = 5'd9;
    #4; check_model(); advance();
    p_v = 3'b111; iss_v = 1'b0;
    chk("pre_rst_rw", {31'd0, RegWrite}, 32'd1);
    chk("pre_rst_busy", {31'd0, rs_busy}, 32'd1);
    #1; rst = 1'b1; #1;
    chk("arst_rw", {31'd0, RegWrite}, 32'd0);
    chk("arst_stall", {16'd0, stall_cnt}, 32'd0);
    chk("arst_rs_busy", {31'd0, rs_busy}, 32'd0);
    chk("arst_rt_busy", {31'd0, rt_busy}, 32'd0);
    chk("arst_ready", {29'd0, md_ready, mem_ready, alu_ready}, 32'd0);
    model_reset();
    #2; check_model(); advance();
    rst = 1'b0;
    #4; check_model();
    chk("post_rst_first_alu", {29'd0, md_ready, mem_ready, alu_ready}, 32'd1);
    advance();

    // Random traffic; producers hold payload until granted unless they drop valid.
    for (int c = 0; c < 400; c++) begin
      for (int j = 0; j < 3; j++) begin
        if (!(p_v[j] && last_g != j && $urandom_range(0, 3) != 0)) begin
          p_v[j] = 1'($urandom_range(0, 1));
          p_a[j] = 5'($urandom_range(0, 31));
          p_d[j] = $urandom;
        end
      end
      iss_v = 1'($urandom_range(0, 1));
      iss_a = 5'($urandom_range(0, 31));
      rs_a  = 5'($urandom_range(0, 31));
      rt_a  = 5'($urandom_range(0, 31));
      #4; check_model(); advance();
    end

    // Continuous contention drives the stall counter into saturation.
    p_v = 3'b111; iss_v = 1'b0;
    for (int c = 0; c < 70000; c++) begin
      p_a[c % 3] = 5'($urandom_range(0, 31));
      rs_a = 5'($urandom_range(0, 31));
      #4; check_model(); advance();
    end
    #4;
    chk("stall_saturated", {16'd0, stall_cnt}, 32'h0000FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
